// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the sized data memory.
//   SIZE_*  : access size codes as driven by the MA stage on SizeIn.
//   state_t : sequencer states of dmem_sized (clearing vs. serving requests).
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;   // reserved, always reported as misaligned

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for dmem_sized.
// Store side (current request):
//   st_size, st_off  : access size code and byte offset AddrIn[1:0]
//   st_data          : right-justified store data
//   byte_en          : per-lane write enable (0 when misaligned)
//   wr_data          : store data replicated into every lane it may occupy
//   misalign         : size/offset combination is not naturally aligned
// Load side (registered copy of the accepted load):
//   ld_size, ld_off, ld_unsigned : size, offset and extension mode of the load
//   rd_word          : word read from the array
//   ld_value         : selected lane(s), sign- or zero-extended to 32 bits
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_data,
    output logic        misalign,
    output logic [31:0] ld_value
);

    logic [31:0] rd_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        misalign = 1'b0;
        byte_en  = 4'b0000;
        wr_data  = st_data;
        case (st_size)
            SIZE_B: begin
                byte_en = 4'b0001 << st_off;
                wr_data = {4{st_data[7:0]}};
            end
            SIZE_H: begin
                misalign = st_off[0];
                byte_en  = st_off[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{st_data[15:0]}};
            end
            SIZE_W: begin
                misalign = (st_off != 2'b00);
                byte_en  = 4'b1111;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
        // A misaligned access must never touch the array.
        if (misalign) begin
            byte_en = 4'b0000;
        end
    end

    // Little-endian: byte offset k lives in bits [8k+7:8k].
    assign rd_shifted = rd_word >> {ld_off, 3'b000};
    assign ld_byte    = rd_shifted[7:0];
    assign ld_half    = ld_off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_value = 32'h0000_0000;
        case (ld_size)
            SIZE_B:  ld_value = ld_unsigned ? {24'h000000, ld_byte}
                                            : {{24{ld_byte[7]}}, ld_byte};
            SIZE_H:  ld_value = ld_unsigned ? {16'h0000, ld_half}
                                            : {{16{ld_half[15]}}, ld_half};
            SIZE_W:  ld_value = rd_word;
            default: ld_value = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized: byte/half/word data memory for the MA stage.
// Ports:
//   clkIn, resetIn           : clock and synchronous active-high reset
//   ReqIn, WriteIn, SizeIn,
//   UnsignedIn, AddrIn,
//   DataIn                   : access request from EXMA (sampled when ReqIn && ReadyOut)
//   ClearIn                  : start a runtime clear of the whole array
//   ReadyOut                 : registered, high while serving requests
//   ValidOut                 : one-cycle response pulse, exactly one cycle after acceptance
//   DataOut                  : load result, 0 for store acks, errors and idle cycles
//   MisalignOut              : error flag, qualified by ValidOut
// The array is built as four byte-wide lanes so byte enables map onto
// independent block RAMs with a registered read port each.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clkIn,
    input  logic              resetIn,
    input  logic              ReqIn,
    input  logic              WriteIn,
    input  logic [1:0]        SizeIn,
    input  logic              UnsignedIn,
    input  logic [ADDR_W-1:0] AddrIn,
    input  logic [31:0]       DataIn,
    input  logic              ClearIn,
    output logic              ReadyOut,
    output logic              ValidOut,
    output logic [31:0]       DataOut,
    output logic              MisalignOut
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state_reg;
    logic [IDX_W-1:0] cnt_reg;
    logic             ready_reg;
    logic             valid_reg;
    logic             mis_reg;
    logic             load_reg;
    logic [1:0]       ld_size_reg;
    logic [1:0]       ld_off_reg;
    logic             ld_uns_reg;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] wr_addr;
    logic [3:0]       byte_en;
    logic [31:0]      wr_data;
    logic             misalign;
    logic [31:0]      rd_word;
    logic [31:0]      ld_value;
    logic             accept;
    logic             clearing;
    logic             do_store;
    logic             do_load;

    // Upper address bits intentionally wrap; fold them here so they count as read.
    logic unused_addr_bits;
    assign unused_addr_bits = ^AddrIn;

    assign idx = AddrIn[IDX_W+1:2];

    // ready_reg is only ever high in ST_IDLE, so it alone qualifies acceptance.
    // A request coinciding with reset is dropped entirely.
    assign accept   = ReqIn && ready_reg && !resetIn;
    assign clearing = (state_reg == ST_CLEAR) && !resetIn;
    assign do_store = accept && WriteIn && !misalign;
    assign do_load  = accept && !WriteIn && !misalign;
    assign wr_addr  = clearing ? cnt_reg : idx;

    dmem_lane_align u_align (
        .st_size     (SizeIn),
        .st_off      (AddrIn[1:0]),
        .st_data     (DataIn),
        .ld_size     (ld_size_reg),
        .ld_off      (ld_off_reg),
        .ld_unsigned (ld_uns_reg),
        .rd_word     (rd_word),
        .byte_en     (byte_en),
        .wr_data     (wr_data),
        .misalign    (misalign),
        .ld_value    (ld_value)
    );

    // Clearing and request stores never coincide (ready_reg is low in
    // ST_CLEAR), so one write port per lane serves both.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clkIn) begin
                if (clearing || (do_store && byte_en[gi])) begin
                    mem[wr_addr] <= clearing ? 8'h00 : wr_data[gi*8 +: 8];
                end
                if (do_load) begin
                    rd_q <= mem[idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_q;
        end
    endgenerate

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_reg   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt_reg     <= '0;
            ready_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            mis_reg     <= 1'b0;
            load_reg    <= 1'b0;
            ld_size_reg <= SIZE_B;
            ld_off_reg  <= 2'b00;
            ld_uns_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    cnt_reg <= cnt_reg + IDX_W'(1);
                    if (cnt_reg == IDX_W'(DEPTH - 1)) begin
                        state_reg <= ST_IDLE;
                        ready_reg <= 1'b1;
                    end else begin
                        ready_reg <= 1'b0;
                    end
                end
                default: begin
                    if (ClearIn) begin
                        state_reg <= ST_CLEAR;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b0;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
            endcase

            // Response stage: every field falls back to 0 on non-accepting edges.
            valid_reg <= accept;
            mis_reg   <= accept && misalign;
            load_reg  <= do_load;
            if (do_load) begin
                ld_size_reg <= SizeIn;
                ld_off_reg  <= AddrIn[1:0];
                ld_uns_reg  <= UnsignedIn;
            end
        end
    end

    assign ReadyOut    = ready_reg;
    assign ValidOut    = valid_reg;
    assign MisalignOut = mis_reg;
    assign DataOut     = load_reg ? ld_value : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: directed plus randomized checks of dmem_sized against a
// byte-addressed reference memory.
module tb_dmem_sized;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam int NBYTES = 4 * DEPTH;

    logic        clkIn = 1'b0;
    logic        resetIn = 1'b1;
    logic        ReqIn = 1'b0;
    logic        WriteIn = 1'b0;
    logic [1:0]  SizeIn = 2'b00;
    logic        UnsignedIn = 1'b0;
    logic [31:0] AddrIn = 32'h0;
    logic [31:0] DataIn = 32'h0;
    logic        ClearIn = 1'b0;
    logic        ReadyOut;
    logic        ValidOut;
    logic [31:0] DataOut;
    logic        MisalignOut;

    int n_cmp = 0;
    int n_mis = 0;

    byte unsigned model_mem [NBYTES];

    dmem_sized #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clkIn       (clkIn),
        .resetIn     (resetIn),
        .ReqIn       (ReqIn),
        .WriteIn     (WriteIn),
        .SizeIn      (SizeIn),
        .UnsignedIn  (UnsignedIn),
        .AddrIn      (AddrIn),
        .DataIn      (DataIn),
        .ClearIn     (ClearIn),
        .ReadyOut    (ReadyOut),
        .ValidOut    (ValidOut),
        .DataOut     (DataOut),
        .MisalignOut (MisalignOut)
    );

    always #5 clkIn = ~clkIn;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
    endfunction

    // Reference behaviour: byte-addressed memory, addresses modulo 4*DEPTH.
    function automatic void model_access(input bit w, input bit [1:0] sz, input bit uns,
                                         input bit [31:0] addr, input bit [31:0] data,
                                         output bit [31:0] rdata, output bit mis);
        int nb;
        int a;
        rdata = 32'h0;
        mis = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
        if (mis) return;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        a  = int'(addr % NBYTES);
        if (w) begin
            for (int i = 0; i < nb; i++) model_mem[a + i] = data[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) rdata |= 32'(model_mem[a + i]) << (8 * i);
            if (!uns && nb < 4 && rdata[8*nb - 1]) rdata |= 32'hFFFF_FFFF << (8 * nb);
        end
    endfunction

    // One request, response checked right after the accepting edge (latency 1).
    task automatic xact(input string tag, input bit w, input bit [1:0] sz, input bit uns,
                        input bit [31:0] addr, input bit [31:0] data, input bit clr);
        bit [31:0] exp_d;
        bit        exp_m;
        ReqIn = 1'b1; WriteIn = w; SizeIn = sz; UnsignedIn = uns;
        AddrIn = addr; DataIn = data; ClearIn = clr;
        @(posedge clkIn); #1;
        ReqIn = 1'b0; ClearIn = 1'b0;
        model_access(w, sz, uns, addr, data, exp_d, exp_m);
        check({tag, ".valid"}, 32'(ValidOut), 32'd1);
        check({tag, ".data"}, DataOut, exp_d);
        check({tag, ".mis"}, 32'(MisalignOut), 32'(exp_m));
        $display("xact %s w=%0d sz=%0d u=%0d addr=%08h wdata=%08h -> data=%08h mis=%0d",
                 tag, w, sz, uns, addr, data, DataOut, MisalignOut);
    endtask

    task automatic idle(input string tag);
        ReqIn = 1'b0;
        @(posedge clkIn); #1;
        check({tag, ".valid"}, 32'(ValidOut), 32'd0);
        check({tag, ".data"}, DataOut, 32'h0);
        check({tag, ".mis"}, 32'(MisalignOut), 32'd0);
    endtask

    // Counts cycles with ReadyOut low; optionally drives loads meanwhile,
    // which must all be ignored.
    task automatic count_clear(input string tag, input bit req_during);
        int n = 0;
        bit seen_valid = 1'b0;
        if (req_during) begin
            ReqIn = 1'b1; WriteIn = 1'b0; SizeIn = 2'b10; AddrIn = 32'h0;
        end
        while (n < 4 * DEPTH) begin
            @(negedge clkIn);
            if (ValidOut) seen_valid = 1'b1;
            if (ReadyOut) break;
            n++;
        end
        ReqIn = 1'b0;
        check({tag, ".low_cycles"}, 32'(n), 32'(DEPTH));
        if (req_during) check({tag, ".no_valid"}, 32'(seen_valid), 32'd0);
        $display("clear %s: ReadyOut low for %0d cycles", tag, n);
        model_clear();
    endtask

    initial begin
        bit [31:0] r;
        bit [31:0] addr;
        bit [1:0]  sz;

        // Reset state
        @(posedge clkIn); #1;
        check("reset.ready", 32'(ReadyOut), 32'd0);
        check("reset.valid", 32'(ValidOut), 32'd0);
        check("reset.data", DataOut, 32'h0);
        check("reset.mis", 32'(MisalignOut), 32'd0);
        resetIn = 1'b0;
        count_clear("reset_clear", 1'b0);
        xact("ld_3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0);

        // Byte/half extraction
        xact("st_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 4; i++) xact("ldb_s", 1'b0, 2'b00, 1'b0, 32'h10 + 32'(i), 32'h0, 1'b0);
        xact("ldh_u12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
        idle("pulse_end");

        // Partial stores
        xact("st_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA, 1'b0);
        xact("sth_22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 1'b0);
        xact("ld_20a", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        xact("stb_21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055, 1'b0);
        xact("ld_20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

        // Misaligned accesses leave memory untouched
        xact("st_04", 1'b1, 2'b10, 1'b0, 32'h04, 32'h01020304, 1'b0);
        xact("mis_h5", 1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1'b0);
        xact("mis_w6", 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, 1'b0);
        xact("mis_x8", 1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 1'b0);
        xact("mis_xs4", 1'b1, 2'b11, 1'b0, 32'h04, 32'hFFFFFFFF, 1'b0);
        xact("ld_04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0);

        // Address wrap, back-to-back
        xact("st_400", 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 1'b0);
        xact("ld_000", 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle("rnd_idle");
            end else begin
                r = $urandom;
                addr = ($urandom_range(0, 1) == 1) ? (r & 32'hFFFF_F03F) : r;
                sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 2) != 0) addr[1:0] = ($urandom_range(0, 1) == 1) ? 2'b00 : addr[1:0];
                xact("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                     addr, $urandom, 1'b0);
            end
        end

        // ClearIn with a same-cycle load
        xact("st_08", 1'b1, 2'b10, 1'b0, 32'h08, 32'h00000011, 1'b0);
        xact("ld_08_clr", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b1);
        check("clr.ready_fall", 32'(ReadyOut), 32'd0);
        count_clear("runtime_clear", 1'b0);
        xact("post_clr_08", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0);
        xact("post_clr_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

        // Reset in the middle of a clear restarts the count
        xact("st_30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h5A5A5A5A, 1'b0);
        ClearIn = 1'b1;
        @(posedge clkIn); #1;
        ClearIn = 1'b0;
        ReqIn = 1'b1; WriteIn = 1'b0; SizeIn = 2'b10; AddrIn = 32'h30;
        repeat (100) @(posedge clkIn);
        #1;
        check("midclr.valid", 32'(ValidOut), 32'd0);
        resetIn = 1'b1;
        @(posedge clkIn); #1;
        resetIn = 1'b0;
        count_clear("midclear_reset", 1'b1);
        xact("post_mid_30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);

        // Reset coinciding with a request drops the response
        xact("st_40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h77777777, 1'b0);
        ReqIn = 1'b1; WriteIn = 1'b0; SizeIn = 2'b10; AddrIn = 32'h40;
        resetIn = 1'b1;
        @(posedge clkIn); #1;
        resetIn = 1'b0; ReqIn = 1'b0;
        check("rst_drop.valid", 32'(ValidOut), 32'd0);
        check("rst_drop.data", DataOut, 32'h0);
        count_clear("reset_drop_clear", 1'b0);
        xact("post_rst_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
